// File: rtl/vga_timing_generator_pkg.sv
// Shared raster types, default 800x600@72 geometry and small decode helpers
// used by the VGA timing generator and anything that needs the screen extents.
package vga_timing_generator_pkg;

    localparam int unsigned CNT_W   = 11;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam int unsigned DEF_H_VISIBLE = 800;
    localparam int unsigned DEF_H_FRONT   = 56;
    localparam int unsigned DEF_H_SYNC    = 120;
    localparam int unsigned DEF_H_BACK    = 64;
    localparam int unsigned DEF_V_VISIBLE = 600;
    localparam int unsigned DEF_V_FRONT   = 37;
    localparam int unsigned DEF_V_SYNC    = 6;
    localparam int unsigned DEF_V_BACK    = 23;

    typedef logic [CNT_W-1:0] coord_t;
    typedef logic [2:0]       rgb_t;

    // Per-pixel timing attributes that travel down the latency-matching pipe.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
    } raster_t;

    function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Raster bus between the timing generator (master) and the game engine / pin
// consumers (slave): coordinates and status out, engine pixel colour back in.
interface vga_timing_generator_if;
    import vga_timing_generator_pkg::*;

    coord_t pixel_h;
    coord_t pixel_v;
    logic   visible;
    logic   vblank_pulse;
    logic   vga_hsync;
    logic   vga_vsync;
    rgb_t   vga_rgb;
    rgb_t   pixel;

    modport master (
        output pixel_h, pixel_v, visible, vblank_pulse,
        output vga_hsync, vga_vsync, vga_rgb,
        input  pixel
    );

    modport slave (
        input  pixel_h, pixel_v, visible, vblank_pulse,
        input  vga_hsync, vga_vsync, vga_rgb,
        output pixel
    );

endinterface

// File: rtl/vga_timing_generator_axis_counter.sv
// Wrapping counter for one raster axis; WRAP flags the enabled clock on which
// the count returns from TOTAL-1 to 0 so it can step the next axis.
module vga_timing_generator_axis_counter
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned TOTAL = DEF_H_VISIBLE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign wrap_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster generator: H/V counters, sync/visible decode, a delay line that
// matches the engine's pixel latency, and a final register stage for the pins.
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter bit          H_POL     = 1'b1,
    parameter bit          V_POL     = 1'b1,
    parameter int unsigned PIXEL_LAT = 1
) (
    input  logic                  VGA_CLOCK,
    input  logic                  RESET_N,
    vga_timing_generator_if.master vga
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_VIS_C    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START_C = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END_C   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START_C = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END_C   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam raster_t RASTER_IDLE = '{hsync: ~H_POL, vsync: ~V_POL, visible: 1'b0};

    generate
        if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_bad_geometry
            $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed 11-bit counters");
        end
    endgenerate

    // Held low for the first clock after reset so (0,0) is presented twice.
    logic run_q;

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    coord_t h_count;
    coord_t v_count;
    logic   h_wrap;
    logic   v_wrap;

    vga_timing_generator_axis_counter #(
        .WIDTH (CNT_W),
        .TOTAL (H_TOTAL)
    ) u_h_counter (
        .clk_i   (VGA_CLOCK),
        .rst_ni  (RESET_N),
        .en_i    (run_q),
        .count_o (h_count),
        .wrap_o  (h_wrap)
    );

    vga_timing_generator_axis_counter #(
        .WIDTH (CNT_W),
        .TOTAL (V_TOTAL)
    ) u_v_counter (
        .clk_i   (VGA_CLOCK),
        .rst_ni  (RESET_N),
        .en_i    (h_wrap),
        .count_o (v_count),
        .wrap_o  (v_wrap)
    );

    raster_t raw;
    logic    vblank;

    always_comb begin
        raw         = RASTER_IDLE;
        raw.visible = run_q && (h_count < H_VIS_C) && (v_count < V_VIS_C);
        if (in_window(h_count, HS_START_C, HS_END_C)) begin
            raw.hsync = H_POL;
        end
        if (in_window(v_count, VS_START_C, VS_END_C)) begin
            raw.vsync = V_POL;
        end
        vblank = run_q && (h_count == '0) && (v_count == V_VIS_C);
    end

    // Delay sync/visible by the engine's pixel latency so they meet PIXEL.
    raster_t dly;

    generate
        if (PIXEL_LAT == 0) begin : g_no_delay
            assign dly = raw;
        end else begin : g_delay
            raster_t shift_q [PIXEL_LAT];

            always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int i = 0; i < PIXEL_LAT; i++) begin
                        shift_q[i] <= RASTER_IDLE;
                    end
                end else begin
                    shift_q[0] <= raw;
                    for (int i = 1; i < PIXEL_LAT; i++) begin
                        shift_q[i] <= shift_q[i-1];
                    end
                end
            end

            assign dly = shift_q[PIXEL_LAT-1];
        end
    endgenerate

    raster_t out_q;
    raster_t out_d;
    rgb_t    rgb_q;
    rgb_t    rgb_d;

    always_comb begin
        out_d = dly;
        rgb_d = dly.visible ? vga.pixel : '0;
    end

    always_ff @(posedge VGA_CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_q <= RASTER_IDLE;
            rgb_q <= '0;
        end else begin
            out_q <= out_d;
            rgb_q <= rgb_d;
        end
    end

    assign vga.pixel_h      = h_count;
    assign vga.pixel_v      = v_count;
    assign vga.visible      = raw.visible;
    assign vga.vblank_pulse = vblank;
    assign vga.vga_hsync    = out_q.hsync;
    assign vga.vga_vsync    = out_q.vsync;
    assign vga.vga_rgb      = rgb_q;

    logic unused_wrap;
    assign unused_wrap = v_wrap;

endmodule
